// File: rtl/adder_64_bist_if.sv
// Operand/result bus between the adder BIST controller (master) and adder_64 (slave).
// Pure wiring: no latency and no flow control on this bus.
interface adder_64_bist_if;
  logic [63:0] a_out;
  logic [63:0] b_out;
  logic        cin_out;
  logic [63:0] sum_in;
  logic        cout_in;

  modport master (output a_out, b_out, cin_out, input sum_in, cout_in);
  modport slave  (input a_out, b_out, cin_out, output sum_in, cout_in);
endinterface

// File: rtl/adder_64_bist.sv
// Self-test for a registered 64-bit adder: 4 corner vectors, then LFSR vectors, each checked LATENCY+1 edges after issue.
// Runs NUM_VEC+LATENCY cycles per start; no backpressure, start is ignored while busy.
module adder_64_bist #(
  parameter int          NUM_VEC = 256,
  parameter int          LATENCY = 1,
  parameter logic [63:0] SEED_A  = 64'h0123_4567_89AB_CDEF,
  parameter logic [63:0] SEED_B  = 64'hFEDC_BA98_7654_3210
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  adder_64_bist_if.master        adder,
  output logic                   busy,
  output logic                   done,
  output logic                   pass,
  output logic [15:0]            err_count,
  output logic [15:0]            fail_index
);

  localparam logic [63:0] LFSR_MASK  = 64'hD800_0000_0000_0000;
  localparam logic [63:0] SEED_A_EFF = (SEED_A == 64'd0) ? 64'd1 : SEED_A;
  localparam logic [63:0] SEED_B_EFF = (SEED_B == 64'd0) ? 64'd1 : SEED_B;
  localparam logic [15:0] LAST_IDX   = 16'(NUM_VEC - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  typedef struct packed {
    logic        vld;
    logic [15:0] idx;
    logic [64:0] exp_sum;
  } dl_t;

  localparam dl_t DL_EMPTY = '0;

  state_t               state_q, state_d;
  logic [15:0]          idx_q, idx_d;
  logic [63:0]          lfsr_a_q, lfsr_a_d;
  logic [63:0]          lfsr_b_q, lfsr_b_d;
  logic [63:0]          a_q, a_d;
  logic [63:0]          b_q, b_d;
  logic                 cin_q, cin_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 pass_q, pass_d;
  logic [15:0]          err_q, err_d;
  logic [15:0]          fail_q, fail_d;
  dl_t  [LATENCY:0]     dl_q, dl_d;
  logic                 issue;
  logic [15:0]          nidx;
  logic                 mismatch;

  // Right-shifting Galois form: the shifted-out bit feeds back into the tap positions.
  function automatic logic [63:0] lfsr_step(input logic [63:0] s);
    return s[0] ? ((s >> 1) ^ LFSR_MASK) : (s >> 1);
  endfunction

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    lfsr_a_d = lfsr_a_q;
    lfsr_b_d = lfsr_b_q;
    a_d      = '0;
    b_d      = '0;
    cin_d    = 1'b0;
    busy_d   = busy_q;
    done_d   = done_q;
    pass_d   = pass_q;
    err_d    = err_q;
    fail_d   = fail_q;
    issue    = 1'b0;
    nidx     = '0;
    dl_d     = {dl_q[LATENCY-1:0], DL_EMPTY};

    mismatch = dl_q[LATENCY].vld && ({adder.cout_in, adder.sum_in} != dl_q[LATENCY].exp_sum);
    if (mismatch) begin
      if (err_q != 16'hFFFF) err_d = err_q + 16'd1;
      if (err_q == 16'd0)    fail_d = dl_q[LATENCY].idx;
    end

    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d  = RUN;
          issue    = 1'b1;
          nidx     = 16'd0;
          lfsr_a_d = SEED_A_EFF;
          lfsr_b_d = SEED_B_EFF;
          err_d    = '0;
          fail_d   = '0;
          pass_d   = 1'b0;
          done_d   = 1'b0;
          busy_d   = 1'b1;
        end
      end
      RUN: begin
        if (idx_q == LAST_IDX) begin
          state_d = DRAIN;
        end else begin
          issue = 1'b1;
          nidx  = idx_q + 16'd1;
        end
      end
      DRAIN: begin
        if (dl_q[LATENCY].vld && dl_q[LATENCY].idx == LAST_IDX) begin
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (err_d == 16'd0);
        end
      end
      default: state_d = IDLE;
    endcase

    // The expected sum is pushed on the edge that presents the vector, hence LATENCY+1 stages.
    if (issue) begin
      idx_d = nidx;
      unique case (nidx)
        16'd0: begin
          a_d = '0;
          b_d = '0;
        end
        16'd1: begin
          a_d = '1;
        end
        16'd2: begin
          a_d   = '1;
          cin_d = 1'b1;
        end
        16'd3: begin
          a_d   = 64'hAAAA_AAAA_AAAA_AAAA;
          b_d   = 64'h5555_5555_5555_5555;
          cin_d = 1'b1;
        end
        default: begin
          a_d      = lfsr_a_q;
          b_d      = lfsr_b_q;
          cin_d    = lfsr_a_q[0] ^ lfsr_b_q[0];
          lfsr_a_d = lfsr_step(lfsr_a_q);
          lfsr_b_d = lfsr_step(lfsr_b_q);
        end
      endcase
      dl_d[0].vld     = 1'b1;
      dl_d[0].idx     = nidx;
      dl_d[0].exp_sum = {1'b0, a_d} + {1'b0, b_d} + 65'(cin_d);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      lfsr_a_q <= SEED_A_EFF;
      lfsr_b_q <= SEED_B_EFF;
      a_q      <= '0;
      b_q      <= '0;
      cin_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
      err_q    <= '0;
      fail_q   <= '0;
      dl_q     <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      lfsr_a_q <= lfsr_a_d;
      lfsr_b_q <= lfsr_b_d;
      a_q      <= a_d;
      b_q      <= b_d;
      cin_q    <= cin_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      pass_q   <= pass_d;
      err_q    <= err_d;
      fail_q   <= fail_d;
      dl_q     <= dl_d;
    end
  end

  assign adder.a_out   = a_q;
  assign adder.b_out   = b_q;
  assign adder.cin_out = cin_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign pass          = pass_q;
  assign err_count     = err_q;
  assign fail_index    = fail_q;

endmodule

// File: tb/tb_adder_64_bist.sv
// Directed bench: four BIST instances against correct, sum[0]-stuck, carry-stuck and latency-mismatched adder models.
module tb_adder_64_bist;
  logic clk = 1'b0;
  logic rst_n;
  logic start;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  adder_64_bist_if if0 ();
  adder_64_bist_if if1 ();
  adder_64_bist_if if2 ();
  adder_64_bist_if if3 ();

  logic        busy [4];
  logic        done [4];
  logic        pass [4];
  logic [15:0] errc [4];
  logic [15:0] fidx [4];

  adder_64_bist #(.NUM_VEC(8), .LATENCY(1)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start), .adder(if0.master),
    .busy(busy[0]), .done(done[0]), .pass(pass[0]), .err_count(errc[0]), .fail_index(fidx[0]));
  adder_64_bist #(.NUM_VEC(8), .LATENCY(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .adder(if1.master),
    .busy(busy[1]), .done(done[1]), .pass(pass[1]), .err_count(errc[1]), .fail_index(fidx[1]));
  adder_64_bist #(.NUM_VEC(8), .LATENCY(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start), .adder(if2.master),
    .busy(busy[2]), .done(done[2]), .pass(pass[2]), .err_count(errc[2]), .fail_index(fidx[2]));
  adder_64_bist #(.NUM_VEC(4), .LATENCY(1)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start), .adder(if3.master),
    .busy(busy[3]), .done(done[3]), .pass(pass[3]), .err_count(errc[3]), .fail_index(fidx[3]));

  // Single-cycle registered adder models; if1 has sum[0] stuck at 0, if3 has carry stuck at 0.
  always_ff @(posedge clk) begin
    {if0.cout_in, if0.sum_in} <= {1'b0, if0.a_out} + {1'b0, if0.b_out} + 65'(if0.cin_out);
    {if1.cout_in, if1.sum_in} <= ({1'b0, if1.a_out} + {1'b0, if1.b_out} + 65'(if1.cin_out)) & ~65'd1;
    {if2.cout_in, if2.sum_in} <= {1'b0, if2.a_out} + {1'b0, if2.b_out} + 65'(if2.cin_out);
    {if3.cout_in, if3.sum_in} <= ({1'b0, if3.a_out} + {1'b0, if3.b_out} + 65'(if3.cin_out)) & {1'b0, {64{1'b1}}};
  end

  task automatic chk(input string tag, input logic [135:0] obs, input logic [135:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [128:0] vec0();
    return {if0.a_out, if0.b_out, if0.cin_out};
  endfunction

  initial begin
    logic [128:0] run1 [8];
    int nbusy;
    int k;

    rst_n = 1'b0;
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_vec", vec0(), '0);
    chk("rst_busy", busy[0], 0);
    chk("rst_done", done[0], 0);
    chk("rst_pass", pass[0], 0);
    chk("rst_err", errc[0], 0);
    chk("rst_fidx", fidx[0], 0);
    rst_n = 1'b1;

    // First run: single-cycle start pulse; j counts negedges after E_j.
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    nbusy = 0;
    for (int j = 0; j < 14; j++) begin
      if (busy[0]) nbusy++;
      if (j == 0) chk("v0", vec0(), '0);
      if (j == 1) chk("v1", vec0(), {64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b0});
      if (j == 2) begin
        chk("v2", vec0(), {64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1});
        chk("v1_result", {if0.cout_in, if0.sum_in}, {1'b0, 64'hFFFF_FFFF_FFFF_FFFF});
      end
      if (j == 3) begin
        chk("v3", vec0(), {64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555, 1'b1});
        chk("v2_result", {if0.cout_in, if0.sum_in}, {1'b1, 64'd0});
      end
      if (j == 4) begin
        chk("v4_seeds", vec0(), {64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 1'b1});
        chk("v3_result", {if0.cout_in, if0.sum_in}, {1'b1, 64'd0});
      end
      if (j == 5) begin
        chk("v5_lfsr", vec0(), {64'hD891_A2B3_C4D5_E6F7, 64'h7F6E_5D4C_3B2A_1908, 1'b1});
        chk("cstuck_done", done[3], 1);
        chk("cstuck_err", errc[3], 2);
        chk("cstuck_fidx", fidx[3], 2);
        chk("cstuck_pass", pass[3], 0);
      end
      if (j == 8) chk("busy_done_e8", {busy[0], done[0]}, 2'b10);
      if (j == 9) begin
        chk("ok_status", {busy[0], done[0], pass[0]}, 3'b011);
        chk("ok_err_fidx", {errc[0], fidx[0]}, 32'd0);
        chk("ok_idle_vec", vec0(), '0);
        chk("s0_done_pass", {done[1], pass[1]}, 2'b10);
        chk("s0_fidx", fidx[1], 1);
        chk("s0_err_ge1", errc[1] != 16'd0, 1);
      end
      if (j == 10) begin
        chk("lat2_done_pass", {done[2], pass[2]}, 2'b10);
        chk("lat2_fidx", fidx[2], 0);
      end
      @(negedge clk);
    end
    chk("busy_cycles", nbusy, 9);

    // Reset asserted while vector 3 is on the bus.
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid_v3", vec0(), {64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555, 1'b1});
    rst_n = 1'b0;
    #1;
    chk("midrst_vec", vec0(), '0);
    chk("midrst_status", {busy[0], done[0], pass[0], errc[0], fidx[0]}, '0);
    chk("midrst_s0_err", errc[1], 0);
    @(negedge clk); rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_rst_idle", {busy[0], done[0]}, 2'b00);

    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    k = 0;
    while (!done[0] && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk("clean_done", done[0], 1);
    chk("clean_pass", pass[0], 1);
    chk("clean_err", errc[0], 0);

    // Back-to-back runs with start held high.
    @(negedge clk); start = 1'b1;
    @(negedge clk);
    for (int j = 0; j < 18; j++) begin
      if (j < 8) run1[j] = vec0();
      if (j == 9) begin
        chk("b2b_done1", done[0], 1);
        chk("b2b_s0_err1", errc[1] != 16'd0, 1);
      end
      if (j == 10) begin
        chk("b2b_restart", {busy[0], done[0]}, 2'b10);
        chk("b2b_s0_err_clr", errc[1], 0);
      end
      if (j >= 10) chk($sformatf("b2b_v%0d", j - 10), vec0(), run1[j - 10]);
      @(negedge clk);
    end
    start = 1'b0;
    k = 0;
    while (!done[0] && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk("b2b_done2_pass", {done[0], pass[0]}, 2'b11);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/adder_64_bist.md
# adder_64_bist

Self-checking stimulus/response controller for `adder_64`, the registered 64-bit adder with `a_in`, `b_in`, `carry_in`, `sum_out` and `carry_out`. On `start` it drives a fixed set of corner vectors followed by pseudo-random vectors into the adder's operand ports. It computes the expected `{carry, sum}` internally, delays it to match the adder's registered latency, compares it against the adder outputs, and reports error count, first failing vector and pass/fail. It sits alongside `adder_64` for bring-up and in-system self-test.

## Interface
- `NUM_VEC`, default 256: total vectors per run, including 4 corner vectors. Must be at least 4 and at most 65535.
- `LATENCY`, default 1: number of rising edges between the edge that captures operands in the adder and the edge at which its result is stable for sampling. Range 1..8.
- `SEED_A`, default 64'h0123_4567_89AB_CDEF: seed for the A-operand LFSR. A seed of 0 is replaced by 1.
- `SEED_B`, default 64'hFEDC_BA98_7654_3210: seed for the B-operand LFSR. A seed of 0 is replaced by 1.
- `clk` in 1: the single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: run request. Sampled only in IDLE or DONE.
- `a_out` out 64: drives adder `a_in`.
- `b_out` out 64: drives adder `b_in`.
- `cin_out` out 1: drives adder `carry_in`.
- `sum_in` in 64: from adder `sum_out`.
- `cout_in` in 1: from adder `carry_out`.
- `busy` out 1: high while a run is in progress.
- `done` out 1: level signal, held until the next accepted `start`.
- `pass` out 1: meaningful only while `done` is high. 1 means zero mismatches.
- `err_count` out 16: mismatch count, saturates at 16'hFFFF.
- `fail_index` out 16: index of the first mismatching vector. Holds 0 if there were none.

## Operation
- States and transitions:
  - IDLE → RUN on `start`.
  - RUN → DRAIN after vector NUM_VEC-1 has been issued.
  - DRAIN → DONE after the last comparison.
  - DONE → RUN on `start`.
- `start` is ignored in RUN and DRAIN.
- On start acceptance:
  - vector index is cleared;
  - both LFSRs are reloaded from their seeds;
  - `err_count`, `fail_index`, `pass` and `done` are cleared;
  - `busy` is set.
- Vectors:
  - v0: a=0, b=0, cin=0.
  - v1: a=all ones, b=0, cin=0.
  - v2: a=all ones, b=0, cin=1.
  - v3: a=64'hAAAA_AAAA_AAAA_AAAA, b=64'h5555_5555_5555_5555, cin=1.
  - v4 onward: a = LFSR-A state, b = LFSR-B state, cin = a[0]^b[0]. Both LFSRs step once per random vector issued.
- LFSRs: 64-bit Galois, polynomial x^64+x^63+x^61+x^60+1.
- Expected value is the 65-bit sum a+b+cin. It is pushed into a LATENCY+1 deep delay line together with a valid bit and its vector index.
- Comparison: when a valid entry leaves the delay line, `{cout_in, sum_in}` is compared with the stored expected value.
- On mismatch:
  - `err_count` increments, saturating;
  - if this is the first error of the run, `fail_index` latches the vector index.
- Outside RUN, `a_out`, `b_out` and `cin_out` are driven to 0.
- `pass` is set together with `done` when `err_count` is 0.
- Reset, asynchronous at any time, including mid-run:
  - state goes to IDLE;
  - all outputs go to 0;
  - the delay line is invalidated;
  - no partial results are kept.

## Timing
- Reset values: `a_out`=0, `b_out`=0, `cin_out`=0, `busy`=0, `done`=0, `pass`=0, `err_count`=0, `fail_index`=0.
- `start` sampled high at edge E0: vector k is presented on `a_out`/`b_out`/`cin_out` from E_k to E_(k+1), for k=0..NUM_VEC-1.
- Vector k is compared at edge E_(k+1+LATENCY).
- `busy` rises at E0 and falls at E_(NUM_VEC+LATENCY).
- `done`, `pass`, final `err_count` and `fail_index` update at E_(NUM_VEC+LATENCY).
- Total run length is NUM_VEC+LATENCY cycles.
- `start` held high continuously: a new run is accepted on the first edge in DONE. `done` drops at that edge.
- `err_count` may update mid-run. `fail_index` changes at most once per run.

## Test plan
- Correct `adder_64`, NUM_VEC=8, LATENCY=1, single-cycle `start` at E0:
  - `busy` is high for exactly 9 cycles;
  - `done`=1 and `pass`=1 after E9;
  - `err_count`=0, `fail_index`=0;
  - v2 and v3 each observe sum=0, carry=1.
- Adder model with `sum_out[0]` stuck at 0, NUM_VEC=8: v1 fails first, so `fail_index`=1, `err_count`≥1, `pass`=0.
- Correct adder with LATENCY=2 and a 1-cycle adder: `pass`=0 and `fail_index`=0, because v0 is compared against v1's result (sum=all ones).
- Adder model with `carry_out` stuck at 0, NUM_VEC=4: v2 and v3 fail, so `err_count`=2, `fail_index`=2.
- `rst_n` pulsed low during RUN at vector 3: all outputs are 0 immediately. After release, state is IDLE and `done`=0. A new `start` gives a full clean run with `pass`=1.
- Two back-to-back runs with `start` held high: the second run's vector sequence is identical to the first (LFSRs reseeded), and `err_count` restarts from 0.
